// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - opcode/funct constants and counter helper for the branch unit
package branch_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  // Saturating 2-bit counter step: taken moves toward 11, not-taken toward 00.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'd1;
    if (!taken && ctr != 2'b00) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational branch/jump outcome and conditional-branch flag
module branch_resolve
  import branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        rt,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              take_branch,
  output logic              is_cond
);

  logic a_neg;
  logic a_zero;
  logic unused_rt;

  assign a_neg     = src_a[DATA_W-1];
  assign a_zero    = ~|src_a;
  // Only rt[0] distinguishes the REGIMM compare; the link variants resolve identically.
  assign unused_rt = ^rt[4:1];

  // Decode the opcode and evaluate the matching compare against zero or src_b.
  always_comb begin
    take_branch = 1'b0;
    is_cond     = 1'b0;
    case (opcode)
      OP_BEQ: begin
        is_cond     = 1'b1;
        take_branch = (src_a == src_b);
      end
      OP_BNE: begin
        is_cond     = 1'b1;
        take_branch = (src_a != src_b);
      end
      OP_BLEZ: begin
        is_cond     = 1'b1;
        take_branch = a_neg | a_zero;
      end
      OP_BGTZ: begin
        is_cond     = 1'b1;
        take_branch = ~a_neg & ~a_zero;
      end
      OP_REGIMM: begin
        is_cond     = 1'b1;
        take_branch = rt[0] ? ~a_neg : a_neg;
      end
      OP_J, OP_JAL: begin
        take_branch = 1'b1;
      end
      OP_SPECIAL: begin
        take_branch = (funct == FN_JR) || (funct == FN_JALR);
      end
      default: begin
        take_branch = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - execute-stage resolution plus 2-bit counter predictor (BRANCH_GSHARE_EN selects gshare indexing)
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 64,
  parameter int HIST_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic              if_stall,
  input  logic [31:0]       if_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [31:0]       ex_pc,
  input  logic [5:0]        ex_opcode,
  input  logic [5:0]        ex_funct,
  input  logic [4:0]        ex_rt,
  input  logic [DATA_W-1:0] ex_src_a,
  input  logic [DATA_W-1:0] ex_src_b,
  input  logic              ex_pred_taken,
  output logic              take_branch,
  output logic              is_cond,
  output logic              mispredict,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [1:0]       ctr_tbl [ENTRIES];
  logic             res_take;
  logic             res_cond;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic             unused_pc;

  branch_resolve #(.DATA_W(DATA_W)) u_resolve (
    .opcode      (ex_opcode),
    .funct       (ex_funct),
    .rt          (ex_rt),
    .src_a       (ex_src_a),
    .src_b       (ex_src_b),
    .take_branch (res_take),
    .is_cond     (res_cond)
  );

  assign take_branch = ex_valid & res_take;
  assign is_cond     = ex_valid & res_cond;
  assign mispredict  = is_cond & (take_branch != ex_pred_taken);

  // PC bits outside the word-aligned index field deliberately alias.
  assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

`ifdef BRANCH_GSHARE_EN
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  ghr_ext;

  assign ghr_ext    = IDX_W'(ghr);
  assign lookup_idx = if_pc[IDX_W+1:2] ^ ghr_ext;
  assign update_idx = ex_pc[IDX_W+1:2] ^ ghr_ext;

  // Non-speculative history: shift in each resolved conditional outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (is_cond) begin
      ghr <= HIST_W'({ghr, take_branch});
    end
  end
`else
  assign lookup_idx = if_pc[IDX_W+1:2];
  assign update_idx = ex_pc[IDX_W+1:2];
`endif

  // Counter table: reset to weakly not-taken, trained by every resolved conditional branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_tbl[i] <= CTR_WEAK_NT;
      end
    end else if (is_cond) begin
      ctr_tbl[update_idx] <= ctr_next(ctr_tbl[update_idx], take_branch);
    end
  end

  // Prediction register: reads the pre-update counter, holds while fetch is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else if (!if_stall) begin
      pred_valid <= if_valid;
      pred_taken <= if_valid & ctr_tbl[lookup_idx][1];
    end
  end

  // Saturating statistics for the CP0/MMIO counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (is_cond && stat_branches != '1) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict && stat_mispredicts != '1) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - randomized self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

  localparam int DATA_W  = 32;
  localparam int ENTRIES = 64;
  localparam int HIST_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_valid;
  logic              if_stall;
  logic [31:0]       if_pc;
  logic              pred_valid;
  logic              pred_taken;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [5:0]        ex_opcode;
  logic [5:0]        ex_funct;
  logic [4:0]        ex_rt;
  logic [DATA_W-1:0] ex_src_a;
  logic [DATA_W-1:0] ex_src_b;
  logic              ex_pred_taken;
  logic              take_branch;
  logic              is_cond;
  logic              mispredict;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: counters as plain integers 0..3, statistics as wide integers.
  int     m_ctr [ENTRIES];
  int     m_ghr;
  bit     m_pv;
  bit     m_pt;
  longint m_br;
  longint m_mp;

  always #5 clk = ~clk;

  branch_predict_unit #(.DATA_W(DATA_W), .ENTRIES(ENTRIES), .HIST_W(HIST_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_valid         (if_valid),
    .if_stall         (if_stall),
    .if_pc            (if_pc),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_opcode        (ex_opcode),
    .ex_funct         (ex_funct),
    .ex_rt            (ex_rt),
    .ex_src_a         (ex_src_a),
    .ex_src_b         (ex_src_b),
    .ex_pred_taken    (ex_pred_taken),
    .take_branch      (take_branch),
    .is_cond          (is_cond),
    .mispredict       (mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  function automatic void ref_resolve(input bit v, input bit [5:0] op, input bit [5:0] fn,
                                      input bit [4:0] rt, input bit [31:0] a, input bit [31:0] b,
                                      output bit take, output bit cond);
    int sa;
    sa   = $signed(a);
    take = 1'b0;
    cond = 1'b0;
    if (!v) return;
    case (op)
      6'd4: begin cond = 1'b1; take = (a == b); end
      6'd5: begin cond = 1'b1; take = (a != b); end
      6'd6: begin cond = 1'b1; take = (sa <= 0); end
      6'd7: begin cond = 1'b1; take = (sa > 0); end
      6'd1: begin cond = 1'b1; take = rt[0] ? (sa >= 0) : (sa < 0); end
      6'd2, 6'd3: take = 1'b1;
      6'd0: take = (fn == 6'd8) || (fn == 6'd9);
      default: take = 1'b0;
    endcase
  endfunction

  function automatic int m_idx(input bit [31:0] pc);
    int i;
    i = int'((pc / 32'd4) % 32'(ENTRIES));
`ifdef BRANCH_GSHARE_EN
    i = i ^ (m_ghr % (1 << HIST_W));
`endif
    return i;
  endfunction

  task automatic set_if(input bit v, input bit s, input bit [31:0] pc);
    if_valid = v;
    if_stall = s;
    if_pc    = pc;
  endtask

  task automatic set_ex(input bit v, input bit [31:0] pc, input bit [5:0] op, input bit [5:0] fn,
                        input bit [4:0] rt, input bit [31:0] a, input bit [31:0] b, input bit pt);
    ex_valid      = v;
    ex_pc         = pc;
    ex_opcode     = op;
    ex_funct      = fn;
    ex_rt         = rt;
    ex_src_a      = a;
    ex_src_b      = b;
    ex_pred_taken = pt;
  endtask

  // Advance one clock: update the reference from the inputs present at the edge.
  task automatic tick();
    bit t, c;
    int li, ui;
    ref_resolve(ex_valid, ex_opcode, ex_funct, ex_rt, ex_src_a, ex_src_b, t, c);
    if (rst) begin
      foreach (m_ctr[i]) m_ctr[i] = 1;
      m_ghr = 0; m_pv = 0; m_pt = 0; m_br = 0; m_mp = 0;
    end else begin
      li = m_idx(if_pc);
      ui = m_idx(ex_pc);
      if (!if_stall) begin
        m_pv = if_valid;
        m_pt = if_valid && (m_ctr[li] >= 2);
      end
      if (c) begin
        m_ctr[ui] = t ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1) : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (t != ex_pred_taken && m_mp < 64'hFFFF_FFFF) m_mp++;
        m_ghr = ((m_ghr << 1) | int'(t)) % (1 << HIST_W);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_if(0, 0, 0);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_if(1, 0, 32'h40);
    set_ex(0, 32'h40, 6'd4, 0, 0, 5, 5, 0);
    #1;
    n_checks++; if (take_branch !== 1'b0) $display("FAIL reset_gate_take got %b want 0", take_branch); else n_pass++;
    n_checks++; if (is_cond !== 1'b0) $display("FAIL reset_gate_cond got %b want 0", is_cond); else n_pass++;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL reset_gate_misp got %b want 0", mispredict); else n_pass++;
    tick();
    rst = 1'b0;
    n_checks++; if (pred_valid !== 1'b0) $display("FAIL reset_pv got %b want 0", pred_valid); else n_pass++;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL reset_pt got %b want 0", pred_taken); else n_pass++;
    n_checks++; if (stat_branches !== 32'd0) $display("FAIL reset_br got %0d want 0", stat_branches); else n_pass++;
    n_checks++; if (stat_mispredicts !== 32'd0) $display("FAIL reset_mp got %0d want 0", stat_mispredicts); else n_pass++;
  endtask

  task automatic test_resolve();
    bit [5:0]  ops [8] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd0, 6'd0};
    bit [5:0]  fns [8] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd32};
    bit [4:0]  rts [8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0};
    bit [31:0] as  [8] = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
    bit [31:0] bs  [8] = '{32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    bit        et  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit        ec  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit [5:0]  op_pool [10] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd35};
    bit [5:0]  fn_pool [4]  = '{6'd8, 6'd9, 6'd32, 6'd42};
    bit t, c;
    bit [31:0] a, b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_if(0, 0, 0);
      set_ex(1, 32'h100 + 32'(i * 4), ops[i], fns[i], rts[i], as[i], bs[i], 0);
      #1;
      n_checks++; if (take_branch !== et[i]) $display("FAIL sweep%0d_take got %b want %b", i, take_branch, et[i]); else n_pass++;
      n_checks++; if (is_cond !== ec[i]) $display("FAIL sweep%0d_cond got %b want %b", i, is_cond, ec[i]); else n_pass++;
      n_checks++; if (mispredict !== (ec[i] & et[i])) $display("FAIL sweep%0d_misp got %b want %b", i, mispredict, ec[i] & et[i]); else n_pass++;
      tick();
    end
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: a = 0;
        1: b = a;
        2: a = 32'h8000_0000;
        3: a = 32'd1;
        default: ;
      endcase
      set_if(1, 0, 32'($urandom_range(0, 255)) << 2);
      set_ex($urandom_range(0, 7) != 0, 32'($urandom_range(0, 255)) << 2,
             op_pool[$urandom_range(0, 9)], fn_pool[$urandom_range(0, 3)], 5'($urandom), a, b, 1'($urandom));
      ref_resolve(ex_valid, ex_opcode, ex_funct, ex_rt, ex_src_a, ex_src_b, t, c);
      #1;
      n_checks++; if (take_branch !== t) $display("FAIL rand_res%0d_take op=%0d got %b want %b", i, ex_opcode, take_branch, t); else n_pass++;
      n_checks++; if (is_cond !== c) $display("FAIL rand_res%0d_cond op=%0d got %b want %b", i, ex_opcode, is_cond, c); else n_pass++;
      n_checks++; if (mispredict !== (c & (t != ex_pred_taken))) $display("FAIL rand_res%0d_misp got %b want %b", i, mispredict, c & (t != ex_pred_taken)); else n_pass++;
      tick();
    end
  endtask

  task automatic test_training();
    bit exp_pt [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit taken;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      taken = (k < 4) || (k == 8);
      set_if(1, 0, 32'h40);
      if (k < 9) set_ex(1, 32'h40, 6'd4, 0, 0, 32'd7, taken ? 32'd7 : 32'd8, 0);
      else set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_checks++; if (pred_valid !== 1'b1) $display("FAIL train%0d_pv got %b want 1", k, pred_valid); else n_pass++;
      n_checks++; if (pred_taken !== exp_pt[k]) $display("FAIL train%0d_pt got %b want %b", k, pred_taken, exp_pt[k]); else n_pass++;
      n_checks++; if (pred_taken !== m_pt) $display("FAIL train%0d_model got %b want %b", k, pred_taken, m_pt); else n_pass++;
    end
  endtask

  task automatic test_stats();
    bit taken, wrong;
    do_reset();
    set_if(0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      taken = 1'($urandom);
      wrong = (i == 1) || (i == 4) || (i == 8);
      if (i == 5) set_ex(1, 32'h300, 6'd3, 0, 0, $urandom, $urandom, 1'($urandom));
      else set_ex(1, 32'h200 + 32'(i * 4), 6'd4, 0, 0, 32'd9, taken ? 32'd9 : 32'd3, taken ^ wrong);
      #1;
      if (i == 5) begin
        n_checks++; if (mispredict !== 1'b0) $display("FAIL stats_jal_misp got %b want 0", mispredict); else n_pass++;
      end else begin
        n_checks++; if (mispredict !== wrong) $display("FAIL stats%0d_misp got %b want %b", i, mispredict, wrong); else n_pass++;
      end
      tick();
    end
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (stat_branches !== 32'd10) $display("FAIL stats_br got %0d want 10", stat_branches); else n_pass++;
    n_checks++; if (stat_mispredicts !== 32'd3) $display("FAIL stats_mp got %0d want 3", stat_mispredicts); else n_pass++;
    n_checks++; if (stat_branches !== 32'(m_br)) $display("FAIL stats_br_model got %0d want %0d", stat_branches, m_br); else n_pass++;
  endtask

  task automatic test_collision_stall();
    do_reset();
    set_if(0, 0, 0);
    set_ex(1, 32'h80, 6'd4, 0, 0, 32'd1, 32'd1, 0);
    tick();
    set_if(1, 0, 32'h80);
    set_ex(1, 32'h80, 6'd4, 0, 0, 32'd1, 32'd2, 0);
    tick();
    n_checks++; if (pred_valid !== 1'b1) $display("FAIL collide_pv got %b want 1", pred_valid); else n_pass++;
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL collide_pt got %b want 1", pred_taken); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      set_if(1'($urandom), 1, 32'h80);
      tick();
      n_checks++; if (pred_valid !== 1'b1) $display("FAIL stall%0d_pv got %b want 1", i, pred_valid); else n_pass++;
      n_checks++; if (pred_taken !== 1'b1) $display("FAIL stall%0d_pt got %b want 1", i, pred_taken); else n_pass++;
    end
    set_if(0, 0, 0);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (pred_valid !== 1'b0) $display("FAIL idle_pv got %b want 0", pred_valid); else n_pass++;
    set_if(1, 0, 32'h80);
    tick();
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL after_stall_pt got %b want 0", pred_taken); else n_pass++;
    n_checks++; if (pred_taken !== m_pt) $display("FAIL after_stall_model got %b want %b", pred_taken, m_pt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_if(1, 0, 32'h40);
      set_ex(1, 32'h40, 6'd4, 0, 0, 32'd4, 32'd4, 0);
      tick();
    end
    rst = 1'b1;
    set_if(1, 0, 32'h40);
    set_ex(1, 32'h40, 6'd4, 0, 0, 32'd4, 32'd4, 0);
    tick();
    rst = 1'b0;
    n_checks++; if (pred_valid !== 1'b0) $display("FAIL midrst_pv got %b want 0", pred_valid); else n_pass++;
    n_checks++; if (stat_branches !== 32'd0) $display("FAIL midrst_br got %0d want 0", stat_branches); else n_pass++;
    n_checks++; if (stat_mispredicts !== 32'd0) $display("FAIL midrst_mp got %0d want 0", stat_mispredicts); else n_pass++;
    tick();
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL midrst_ctr01_a got %b want 0", pred_taken); else n_pass++;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL midrst_ctr01_b got %b want 1", pred_taken); else n_pass++;
  endtask

  task automatic test_random();
    bit [31:0] pcs [5] = '{32'h40, 32'h44, 32'h80, 32'h140, 32'h3FC};
    bit [5:0]  op_pool [9] = '{6'd0, 6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd2, 6'd9};
    bit t, c;
    bit [31:0] a;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      a = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      set_if(1'($urandom), $urandom_range(0, 3) == 0, pcs[$urandom_range(0, 4)]);
      set_ex($urandom_range(0, 4) != 0, pcs[$urandom_range(0, 4)], op_pool[$urandom_range(0, 8)],
             6'd8, 5'($urandom), a, ($urandom_range(0, 1) == 0) ? a : $urandom, 1'($urandom));
      ref_resolve(ex_valid, ex_opcode, ex_funct, ex_rt, ex_src_a, ex_src_b, t, c);
      #1;
      n_checks++; if (mispredict !== (c & (t != ex_pred_taken))) $display("FAIL rnd%0d_misp got %b want %b", i, mispredict, c & (t != ex_pred_taken)); else n_pass++;
      tick();
      n_checks++; if (pred_valid !== m_pv) $display("FAIL rnd%0d_pv got %b want %b", i, pred_valid, m_pv); else n_pass++;
      if (m_pv) begin
        n_checks++; if (pred_taken !== m_pt) $display("FAIL rnd%0d_pt got %b want %b", i, pred_taken, m_pt); else n_pass++;
      end
      n_checks++; if (stat_branches !== 32'(m_br)) $display("FAIL rnd%0d_br got %0d want %0d", i, stat_branches, m_br); else n_pass++;
      n_checks++; if (stat_mispredicts !== 32'(m_mp)) $display("FAIL rnd%0d_mp got %0d want %0d", i, stat_mispredicts, m_mp); else n_pass++;
    end
    rst = 1'b0;
  endtask

`ifdef BRANCH_GSHARE_EN
  task automatic test_gshare();
    bit p, t;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      t = 1'(i % 2);
      set_if(1, 0, 32'h0);
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      p = pred_taken;
      n_checks++; if (pred_taken !== m_pt) $display("FAIL gshare%0d_pt got %b want %b", i, pred_taken, m_pt); else n_pass++;
      set_if(0, 0, 32'h0);
      set_ex(1, 32'h0, 6'd4, 0, 0, 32'd1, t ? 32'd1 : 32'd2, p);
      #1;
      if (i >= 24) begin
        n_checks++; if (mispredict !== 1'b0) $display("FAIL gshare%0d_misp got %b want 0", i, mispredict); else n_pass++;
      end
      tick();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_if(0, 0, 0);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_resolve();
    test_training();
    test_stats();
    test_collision_stall();
    test_reset_mid();
    test_random();
`ifdef BRANCH_GSHARE_EN
    test_gshare();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
